// File: rtl/coeff_fetch_seq.sv
// Coefficient fetch sequencer: reads N words from a 1-cycle-latency ROM into a 2-entry FIFO stream.
// Build option: define COEFF_FETCH_REVERSE_EN to issue addresses N-1 down to 0 (last flag on index 0).
module coeff_fetch_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_COEFF  = 33
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] term_count,
    input  logic                  abort,
    output logic                  rom_rd,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  coeff_valid,
    input  logic                  coeff_ready,
    output logic [DATA_WIDTH-1:0] coeff_data,
    output logic [ADDR_WIDTH-1:0] coeff_idx,
    output logic                  coeff_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   MAX_CNT = (ADDR_WIDTH+1)'(NUM_COEFF);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] rem_q, addr_q;
    logic                  err_q;
    logic                  inflight_q, inflight_last_q;
    logic [ADDR_WIDTH-1:0] inflight_idx_q;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [ADDR_WIDTH-1:0] fifo_idx  [2];
    logic                  fifo_last [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            fifo_cnt;

    logic                  count_ok, accept, pop, push, room, rd_last;
    logic [ADDR_WIDTH-1:0] first_addr, next_addr, issue_cnt;
    logic [2:0]            pending;

    assign count_ok = (term_count != '0) && ({1'b0, term_count} <= MAX_CNT);
    assign accept   = (state == IDLE) && start && !abort && count_ok;

`ifdef COEFF_FETCH_REVERSE_EN
    assign first_addr = term_count - ONE;
    assign next_addr  = rom_addr - ONE;
`else
    assign first_addr = '0;
    assign next_addr  = rom_addr + ONE;
`endif

    // The first read goes out in the start cycle itself so the head entry is visible two cycles later.
    assign rom_addr  = (state == IDLE) ? (accept ? first_addr : '0) : addr_q;
    assign issue_cnt = (state == IDLE) ? term_count : rem_q;
    assign rd_last   = (issue_cnt == ONE);

    // Occupancy is counted net of this cycle's pop so a full-rate stream keeps one read outstanding.
    assign pending = {1'b0, fifo_cnt} - {2'b00, pop} + {2'b00, inflight_q};
    assign room    = (pending < 3'd2);
    assign rom_rd  = accept || ((state == FETCH) && room);

    assign push        = inflight_q;
    assign coeff_valid = (fifo_cnt != 2'd0);
    assign pop         = coeff_valid && coeff_ready;
    assign coeff_data  = fifo_data[rd_ptr];
    assign coeff_idx   = fifo_idx[rd_ptr];
    assign coeff_last  = fifo_last[rd_ptr];
    assign busy        = (state != IDLE);
    assign err         = err_q;

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = rd_last ? DRAIN : FETCH;
            end
            FETCH: begin
                if (abort)                  state_nxt = IDLE;
                else if (rom_rd && rd_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if ((fifo_cnt == 2'd0) && !inflight_q) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state           <= IDLE;
            rem_q           <= '0;
            addr_q          <= '0;
            err_q           <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_idx_q  <= '0;
            inflight_last_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= (state == IDLE) && start && !abort && !count_ok;
            if (rom_rd) rem_q <= issue_cnt - ONE;
            if (state_nxt == IDLE) addr_q <= '0;
            else if (rom_rd)       addr_q <= next_addr;
            inflight_q      <= rom_rd && !abort;
            inflight_idx_q  <= rom_addr;
            inflight_last_q <= rd_last;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= '0;
                fifo_last[i] <= 1'b0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else if (abort) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rom_data;
                fifo_idx[wr_ptr]  <= inflight_idx_q;
                fifo_last[wr_ptr] <= inflight_last_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_fetch_seq.sv
// Directed bench for coeff_fetch_seq: ROM model, occupancy model and per-sequence stream checks.
module tb_coeff_fetch_seq;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NC = 33;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, coeff_ready;
    logic [AW-1:0] term_count, rom_addr, coeff_idx;
    logic [DW-1:0] rom_data, coeff_data;
    logic          rom_rd, coeff_valid, coeff_last, busy, done, err;

    int total = 0;
    int bad   = 0;

    int m_occ = 0, m_inf = 0, cycle_no = 0;
    int done_cnt, err_cnt, first_valid, err_cyc;
    int rd_first, rd_lastc, pop_first, pop_lastc;
    bit busy_seen;
    bit hold_pend = 1'b0;
    logic [AW-1:0] h_idx;
    logic [DW-1:0] h_data;
    logic          h_last;
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] got_idx[$];
    logic [DW-1:0] got_data[$];
    logic          got_last[$];

    always #5 clk = ~clk;

    coeff_fetch_seq #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_COEFF (NC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .term_count (term_count),
        .abort      (abort),
        .rom_rd     (rom_rd),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .coeff_valid(coeff_valid),
        .coeff_ready(coeff_ready),
        .coeff_data (coeff_data),
        .coeff_idx  (coeff_idx),
        .coeff_last (coeff_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
        case (a)
            6'd0, 6'd1: return 32'h3f80_0000;
            6'd2:       return 32'h3f00_0000;
            6'd3:       return 32'h3e2a_aaab;
            default:    return 32'hc0de_0000 | {26'd0, a};
        endcase
    endfunction

    // ROM: data valid exactly one cycle after the read, junk otherwise
    always @(posedge clk) rom_data <= rom_rd ? rom_val(rom_addr) : 32'hdead_beef;

    function automatic logic [AW-1:0] exp_index(input int n, input int k);
`ifdef COEFF_FETCH_REVERSE_EN
        return AW'(n - 1 - k);
`else
        return AW'(k);
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cycle_no);
        end
    endtask

    task automatic clear_rec();
        rd_q.delete(); got_idx.delete(); got_data.delete(); got_last.delete();
        done_cnt = 0; err_cnt = 0; busy_seen = 1'b0;
        first_valid = -1; err_cyc = -1;
        rd_first = -1; rd_lastc = -1; pop_first = -1; pop_lastc = -1;
    endtask

    task automatic observe();
        logic pop;
        cycle_no++;
        pop = coeff_valid & coeff_ready;
        check("valid_vs_occ", 64'(coeff_valid), 64'(m_occ != 0));
        if (hold_pend) begin
            check("hold_idx",  64'(coeff_idx),  64'(h_idx));
            check("hold_data", 64'(coeff_data), 64'(h_data));
            check("hold_last", 64'(coeff_last), 64'(h_last));
        end
        hold_pend = coeff_valid && !coeff_ready && !abort;
        h_idx = coeff_idx; h_data = coeff_data; h_last = coeff_last;
        if (rom_rd) begin
            // occupancy net of this cycle's pop, plus the read already outstanding
            check("rd_room", 64'((m_occ - int'(pop) + m_inf) < 2), 64'd1);
            rd_q.push_back(rom_addr);
            if (rd_first < 0) rd_first = cycle_no;
            rd_lastc = cycle_no;
        end
        if (pop) begin
            got_idx.push_back(coeff_idx);
            got_data.push_back(coeff_data);
            got_last.push_back(coeff_last);
            if (pop_first < 0) pop_first = cycle_no;
            pop_lastc = cycle_no;
        end
        if (coeff_valid && first_valid < 0) first_valid = cycle_no;
        if (done) done_cnt++;
        if (err) begin
            err_cnt++;
            if (err_cyc < 0) err_cyc = cycle_no;
        end
        if (busy) busy_seen = 1'b1;
        if (abort) begin
            m_occ = 0; m_inf = 0;
        end else begin
            m_occ = m_occ + m_inf - int'(pop);
            m_inf = int'(rom_rd);
        end
    endtask

    // inputs for the cycle are driven at negedge+1 before calling
    task automatic cyc();
        #1;
        observe();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rom_rd"}, 64'(rom_rd), 64'd0);
        check({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
        check({tag, "_valid"}, 64'(coeff_valid), 64'd0);
        check({tag, "_data"}, 64'(coeff_data), 64'd0);
        check({tag, "_idx"}, 64'(coeff_idx), 64'd0);
        check({tag, "_last"}, 64'(coeff_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    // rmode: 0 = ready held high, 1 = ready toggles 1/0; extra = stray start while busy
    task automatic run_seq(input int n, input int rmode, input bit extra);
        bit fin;
        int start_cyc;
        logic [AW-1:0] ei;
        clear_rec();
        fin = 1'b0;
        start_cyc = 0;
        for (int k = 0; k < 300 && !fin; k++) begin
            start       = (k == 0) || (extra && k == 2);
            term_count  = (k == 0) ? AW'(n) : '0;
            coeff_ready = (rmode == 0) ? 1'b1 : ((k % 2) == 0);
            cyc();
            if (k == 0) start_cyc = cycle_no;
            fin = (done_cnt > 0);
        end
        start = 1'b0; term_count = '0; coeff_ready = 1'b1;
        check("seq_timeout", 64'(fin), 64'd1);
        cyc(); cyc();
        check("done_once", 64'(done_cnt), 64'd1);
        check("err_none", 64'(err_cnt), 64'd0);
        check("first_valid_lat", 64'(first_valid - start_cyc), 64'd2);
        check("rd_count", 64'(rd_q.size()), 64'(n));
        check("out_count", 64'(got_idx.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
            ei = exp_index(n, k);
            if (k < rd_q.size()) check("rd_addr", 64'(rd_q[k]), 64'(ei));
            if (k < got_idx.size()) begin
                check("out_idx", 64'(got_idx[k]), 64'(ei));
                check("out_data", 64'(got_data[k]), 64'(rom_val(ei)));
                check("out_last", 64'(got_last[k]), 64'(k == n - 1));
            end
        end
        if (rmode == 0) begin
            check("rd_back2back", 64'(rd_lastc - rd_first), 64'(n - 1));
            check("out_back2back", 64'(pop_lastc - pop_first), 64'(n - 1));
        end
    endtask

    task automatic bad_count(input int tc);
        int sc;
        clear_rec();
        start = 1'b1; term_count = AW'(tc); coeff_ready = 1'b1;
        cyc();
        sc = cycle_no;
        start = 1'b0; term_count = '0;
        repeat (4) cyc();
        check("err_pulse", 64'(err_cnt), 64'd1);
        check("err_timing", 64'(err_cyc - sc), 64'd1);
        check("err_busy", 64'(busy_seen), 64'd0);
        check("err_no_rd", 64'(rd_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_rd;
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; coeff_ready = 1'b0; term_count = '0;
        clear_rec();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_reset("por");
        rst_n = 1'b0;

        run_seq(3, 0, 1'b0);
        run_seq(4, 0, 1'b0);
        if (got_data.size() > 0) begin
`ifdef COEFF_FETCH_REVERSE_EN
            check("first_data_n4", 64'(got_data[0]), 64'h3e2a_aaab);
`else
            check("first_data_n4", 64'(got_data[0]), 64'h3f80_0000);
`endif
        end
        run_seq(1, 0, 1'b0);
        run_seq(5, 0, 1'b1);
        run_seq(NC, 1, 1'b0);

        bad_count(0);
        bad_count(NC + 1);
        bad_count(63);

        // abort alone in IDLE, then abort together with a valid start
        clear_rec();
        abort = 1'b1; cyc();
        start = 1'b1; term_count = AW'(3); cyc();
        abort = 1'b0; start = 1'b0; term_count = '0;
        repeat (3) cyc();
        check("abort_idle_busy", 64'(busy_seen), 64'd0);
        check("abort_idle_err", 64'(err_cnt), 64'd0);
        check("abort_idle_rd", 64'(rd_q.size()), 64'd0);

        // abort in the cycle after the second read
        clear_rec();
        start = 1'b1; term_count = AW'(5); coeff_ready = 1'b1; cyc();
        start = 1'b0; term_count = '0; cyc();
        abort = 1'b1; cyc();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(coeff_valid), 64'd0);
        n_rd = rd_q.size();
        repeat (4) cyc();
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_no_rd", 64'(rd_q.size()), 64'(n_rd));
        run_seq(3, 0, 1'b0);

        // asynchronous reset while draining
        clear_rec();
        start = 1'b1; term_count = AW'(2); coeff_ready = 1'b0; cyc();
        start = 1'b0; term_count = '0; cyc();
        check("pre_rst_busy", 64'(busy), 64'd1);
        check("pre_rst_valid", 64'(coeff_valid), 64'd1);
        rst_n = 1'b1;
        #1;
        check_reset("mid");
        m_occ = 0; m_inf = 0; hold_pend = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk); #1;
        clear_rec();
        coeff_ready = 1'b1;
        repeat (6) cyc();
        check("rst_no_stale", 64'(got_idx.size()), 64'd0);
        check("rst_no_done", 64'(done_cnt), 64'd0);
        check("rst_idle", 64'(busy_seen), 64'd0);
        run_seq(2, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coeff_fetch_seq.md
COEFF_FETCH_SEQ -- requirements
Module: coeff_fetch_seq

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, coefficient word width; ADDR_WIDTH, 6, ROM address width; NUM_COEFF, 33, number of ROM entries.
REQ-002 SHALL use one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous reset, active-high (name kept from codebase).
REQ-004 SHALL have port start, input, 1 bit, single-cycle request to begin a fetch sequence.
REQ-005 SHALL have port term_count, input, ADDR_WIDTH bits, number of coefficients to fetch, sampled when start is accepted.
REQ-006 SHALL have port abort, input, 1 bit, cancels the sequence in progress.
REQ-007 SHALL have ports rom_rd (output, 1 bit) and rom_addr (output, ADDR_WIDTH bits), the read request and address to the coefficient ROM.
REQ-008 SHALL have port rom_data, input, DATA_WIDTH bits, the ROM read data, valid exactly 1 cycle after rom_rd.
REQ-009 SHALL have ports coeff_valid (output, 1), coeff_ready (input, 1), coeff_data (output, DATA_WIDTH), coeff_idx (output, ADDR_WIDTH) and coeff_last (output, 1), forming the downstream stream.
REQ-010 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and err (output, 1, one-cycle pulse).

Function
REQ-011 SHALL implement three states: IDLE, FETCH, DRAIN.
REQ-012 IDLE: start with 1 <= term_count <= NUM_COEFF SHALL go to FETCH and latch the count; start with any other count SHALL pulse err on the next cycle and stay in IDLE.
REQ-013 SHALL ignore start while busy=1, with no err pulse.
REQ-014 FETCH: SHALL assert rom_rd only when (buffer occupancy + reads in flight) < 2, and SHALL issue at most one read per cycle.
REQ-015 SHALL issue addresses 0,1,...,N-1 in order, incrementing only on cycles where rom_rd=1.
REQ-016 SHALL capture rom_data into a 2-entry FIFO 1 cycle after each rom_rd, tagged with its address and a last flag.
REQ-017 After the Nth read is issued, SHALL go to DRAIN; when the FIFO is empty and no read is in flight, SHALL go to IDLE and pulse done in the same cycle as the transition.
REQ-018 coeff_valid SHALL equal FIFO not empty; coeff_data, coeff_idx and coeff_last SHALL show the FIFO head; an entry SHALL pop on coeff_valid & coeff_ready.
REQ-019 SHALL hold coeff_data, coeff_idx and coeff_last stable while coeff_valid=1 and coeff_ready=0.
REQ-020 Simultaneous push and pop at full occupancy SHALL be legal and SHALL cause no loss; a capture SHALL never overflow the FIFO.
REQ-021 With coeff_ready held high, SHALL sustain 1 coefficient per cycle; the first coeff_valid SHALL appear 2 cycles after start.
REQ-022 abort SHALL, on the next edge, flush the FIFO, discard any in-flight data, deassert rom_rd and return to IDLE with no done pulse; abort in IDLE SHALL have no effect.
REQ-023 abort and start in the same cycle: abort SHALL win.
REQ-024 busy SHALL be 1 in FETCH and DRAIN, and 0 in IDLE.

Reset
REQ-025 Reset SHALL force: state IDLE; rom_rd=0; rom_addr=0; coeff_valid=0; coeff_data=0; coeff_idx=0; coeff_last=0; busy=0; done=0; err=0; FIFO empty; in-flight flag cleared.
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence; the ROM data returned after reset is released SHALL be ignored.

Configuration
REQ-027 Macro COEFF_FETCH_REVERSE_EN, when defined: addresses SHALL be issued N-1 down to 0 (highest order first, for Horner evaluation), and coeff_last SHALL mark index 0.
REQ-028 Macro COEFF_FETCH_REVERSE_EN, when undefined: order SHALL be ascending per REQ-015, and coeff_last SHALL mark index N-1.

Verification
REQ-029 Scenario: start, term_count=3, ready=1 -> rom_addr 0,1,2 on consecutive cycles; outputs 0x3f800000, 0x3f800000, 0x3f000000; coeff_last on idx 2; done pulses once.
REQ-030 Scenario: term_count=0, and separately term_count=34 -> err pulses once each; busy stays 0; rom_rd never asserted.
REQ-031 Scenario: term_count=33 with ready toggling 1/0 every cycle -> all 33 indices delivered in order with no loss or duplication; rom_rd is never asserted when occupancy + in-flight = 2.
REQ-032 Scenario: abort in the cycle after the 2nd rom_rd -> next cycle busy=0, coeff_valid=0, no done; a new start then delivers from idx 0.
REQ-033 Scenario: COEFF_FETCH_REVERSE_EN defined, term_count=4 -> indices 3,2,1,0; first data 0x3e2aaaab; coeff_last on idx 0.
REQ-034 Scenario: reset pulsed during DRAIN -> all outputs match REQ-025 immediately; no stale coefficient appears afterwards.
